rob_multiport: RTL
==================

// Module: rob_multiport
// PURPOSE
//  Parametrised reorder buffer: in-order allocate, out-of-order completion over WB_PORTS
//  writeback buses, in-order single-entry commit to the register file.
//  Provides tag lookup with same-cycle writeback bypass for three decoder operands.
//  Adds a full-pipeline flush for mispredict/exception recovery.
//  Sits between decoder (alloc/lookup), execution units (writeback) and regfile (commit).
// PARAMETERS
//  DATA_W    32  data width of results
//  REG_W     5   architectural destination register index width
//  DEPTH     8   entry count; power of two, >=2
//  WB_PORTS  2   number of writeback buses (ALU, LSU, ...)
//  TAG_W = $clog2(DEPTH)+1 (localparam): MSB=1 means TAG_FREE (operand not renamed)
// PORTS
//  clk          in   1                clock
//  rst          in   1                reset, asynchronous, active-high
//  rdy          in   1                global enable; 0 freezes all state
//  flush        in   1                squash every entry (synchronous)
//  alloc_valid  in   1                decoder requests an entry
//  alloc_dest   in   REG_W            destination register of new entry
//  alloc_ready  out  1                count < DEPTH
//  alloc_tag    out  TAG_W            tag given to the request ({1'b0,tail})
//  look_tag     in   3*TAG_W          three operand tags, [k*TAG_W +: TAG_W]
//  look_ready   out  3                operand k value available
//  look_data    out  3*DATA_W         operand k value
//  wb_valid     in   WB_PORTS         writeback strobe per port
//  wb_tag       in   WB_PORTS*TAG_W   writeback tag per port
//  wb_data      in   WB_PORTS*DATA_W  writeback data per port
//  com_valid    out  1                head entry retires this cycle
//  com_dest     out  REG_W            retiring destination
//  com_data     out  DATA_W           retiring value
//  com_tag      out  TAG_W            retiring tag ({1'b0,head}); regfile clears rename if equal
//  count        out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Per entry: busy, done, dest, data. head, tail ($clog2(DEPTH) bits), count.
//  - Reset: busy/done/data/dest=0, head=tail=count=0 -> alloc_ready=1, alloc_tag=0, com_valid=0.
//  - rdy=0: no state change; com_valid forced 0; lookups still combinational.
//  - Alloc fire = alloc_valid&&alloc_ready&&rdy&&!flush: entry[tail] busy=1, done=0, data=0,
//    dest=alloc_dest; tail wraps DEPTH-1 -> 0. alloc_ready uses registered count only
//    (no same-cycle commit credit); alloc_valid with alloc_ready=0 is ignored.
//  - Writeback: for each port p with wb_valid[p], tag MSB=0 and entry busy: done=1, data=wb_data.
//    wb to non-busy entry or TAG_FREE ignored. Same tag on two ports: lowest p wins.
//  - Commit: com_valid = busy[head]&&done[head]&&rdy&&!flush, combinational from registered
//    state; on fire busy/done[head]=0, head wraps. Max one commit per cycle; no backpressure.
//    Writeback to head completes that edge; commit follows next cycle (1-cycle min latency).
//  - count: +1 alloc only, -1 commit only, unchanged if both.
//  - Lookup k: tag MSB=1 -> ready=1, data=0. Else lowest-index matching valid wb port ->
//    ready=1, data=wb_data (bypass); else ready=done[idx], data=data[idx].
//  - flush (with rdy): dominates alloc/wb/commit same cycle; all busy/done=0, head=tail=count=0.
//  - Full: count==DEPTH, head==tail; empty: count==0, head==tail; distinguish by count only.
//  - rst mid-operation clears everything immediately, independent of clk/rdy.
// TESTING
//  1 rst; alloc dest 3,4,5 -> tags 0,1,2, count=3; wb tag1=0xB then tag0=0xA (port1) ->
//    commits tag0 (dest3,0xA) then tag1 (dest4,0xB) on consecutive cycles; tag2 holds head.
//  2 fill DEPTH=8 -> alloc_ready=0 at count=8; extra alloc ignored; commit one -> ready=1
//    next cycle; next alloc_tag=0 (wrap).
//  3 look_tag0=2 while wb_valid[1] tag2 data 0x55 -> look_ready[0]=1, data 0x55 same cycle;
//    look_tag1=TAG_FREE -> ready=1, data=0.
//  4 both ports write tag 1 (0x11 p0, 0x22 p1) -> entry data 0x11; wb to unallocated tag 6
//    -> no commit, count unchanged.
//  5 4 entries busy, flush with alloc+wb+done head -> com_valid=0, count=0, alloc_tag=0 next.
//  6 rdy=0 with done head and alloc_valid -> com_valid=0, state frozen; rdy=1 resumes commit.

Source files
------------

// File: rtl/rob_multiport.sv
// Reorder buffer: in-order allocate, out-of-order multi-port writeback, in-order single commit.
// Three-operand tag lookup with same-cycle writeback bypass; flush squashes every entry.
module rob_multiport #(
  parameter  int DATA_W   = 32,
  parameter  int REG_W    = 5,
  parameter  int DEPTH    = 8,
  parameter  int WB_PORTS = 2,
  localparam int TAG_W    = $clog2(DEPTH) + 1,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         flush,
  input  logic                         alloc_valid,
  input  logic [REG_W-1:0]             alloc_dest,
  output logic                         alloc_ready,
  output logic [TAG_W-1:0]             alloc_tag,
  input  logic [3*TAG_W-1:0]           look_tag,
  output logic [2:0]                   look_ready,
  output logic [3*DATA_W-1:0]          look_data,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_data,
  output logic                         com_valid,
  output logic [REG_W-1:0]             com_dest,
  output logic [DATA_W-1:0]            com_data,
  output logic [TAG_W-1:0]             com_tag,
  output logic [CNT_W-1:0]             count
);
  localparam int IDX_W = TAG_W - 1;

  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  r_done;
  logic [REG_W-1:0]  r_dest [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [IDX_W-1:0]  r_head;
  logic [IDX_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_alloc_fire;
  logic              w_com_fire;
  logic [DEPTH-1:0]  w_wb_hit;
  logic [DATA_W-1:0] w_wb_val [DEPTH];

  assign alloc_ready  = (r_count < CNT_W'(DEPTH));
  assign alloc_tag    = {1'b0, r_tail};
  assign w_alloc_fire = alloc_valid && alloc_ready && rdy && !flush;
  assign w_com_fire   = r_busy[r_head] && r_done[r_head] && rdy && !flush;
  assign com_valid    = w_com_fire;
  assign com_dest     = r_dest[r_head];
  assign com_data     = r_data[r_head];
  assign com_tag      = {1'b0, r_head};
  assign count        = r_count;

  // Per-entry writeback select; iterating ports downward lets the lowest port win.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_wb_hit[e] = 1'b0;
      w_wb_val[e] = '0;
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
        if (wb_valid[p] && (wb_tag[p*TAG_W +: TAG_W] == TAG_W'(e))) begin
          w_wb_hit[e] = 1'b1;
          w_wb_val[e] = wb_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    logic [TAG_W-1:0] w_tag;
    look_ready = '0;
    look_data  = '0;
    for (int k = 0; k < 3; k++) begin
      w_tag = look_tag[k*TAG_W +: TAG_W];
      if (w_tag[TAG_W-1]) begin
        look_ready[k] = 1'b1;
      end else begin
        look_ready[k]                 = r_done[w_tag[IDX_W-1:0]];
        look_data[k*DATA_W +: DATA_W] = r_data[w_tag[IDX_W-1:0]];
        for (int p = WB_PORTS - 1; p >= 0; p--) begin
          if (wb_valid[p] && (wb_tag[p*TAG_W +: TAG_W] == w_tag)) begin
            look_ready[k]                 = 1'b1;
            look_data[k*DATA_W +: DATA_W] = wb_data[p*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Update order: writeback, then commit clears head, then allocate at tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        r_dest[e] <= '0;
        r_data[e] <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        r_busy  <= '0;
        r_done  <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        for (int e = 0; e < DEPTH; e++) begin
          if (w_wb_hit[e] && r_busy[e]) begin
            r_done[e] <= 1'b1;
            r_data[e] <= w_wb_val[e];
          end
        end
        if (w_com_fire) begin
          r_busy[r_head] <= 1'b0;
          r_done[r_head] <= 1'b0;
          r_head         <= r_head + 1'b1;
        end
        if (w_alloc_fire) begin
          r_busy[r_tail] <= 1'b1;
          r_done[r_tail] <= 1'b0;
          r_data[r_tail] <= '0;
          r_dest[r_tail] <= alloc_dest;
          r_tail         <= r_tail + 1'b1;
        end
        if (w_alloc_fire && !w_com_fire) begin
          r_count <= r_count + 1'b1;
        end else if (!w_alloc_fire && w_com_fire) begin
          r_count <= r_count - 1'b1;
        end
      end
    end
  end
endmodule
